// File: rtl/bpu_pkg.sv
// Shared constants, state encoding and helpers for the instruction fetch unit.
// Optional build macro BPU_FETCH_PERF_EN is consumed by bpu_inst_fetch.
package bpu_pkg;

  localparam int unsigned BPU_ADDR_W       = 16;
  localparam int unsigned BPU_INST_W       = 16;
  localparam int unsigned FETCH_FIFO_DEPTH = 4;
  localparam logic [4:0]  OPC_HALT         = 5'b11111;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain
  } fetch_state_e;

  function automatic logic is_halt(input logic [BPU_INST_W-1:0] word);
    return word[BPU_INST_W-1 -: 5] == OPC_HALT;
  endfunction

endpackage

// File: rtl/bpu_fetch_fifo.sv
// Small synchronous FIFO with flush; head is presented combinationally, zero when empty.
module bpu_fetch_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         wr_en,
  input  logic [Width-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [Width-1:0]             rd_data,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(Depth+1)-1:0]   count
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr, rd_ptr;
  logic             do_wr, do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CntW'(Depth));
  assign do_rd   = rd_en && !empty;
  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !flush) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/bpu_inst_fetch.sv
// Instruction fetch: issues SRAM reads ahead into a 4-entry FIFO, handles redirect and HALT.
// Define BPU_FETCH_PERF_EN to add the saturating stall_cnt output.
module bpu_inst_fetch
  import bpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BPU_ADDR_W-1:0] start_addr,
  input  logic                  redirect,
  input  logic [BPU_ADDR_W-1:0] redirect_addr,
  output logic                  isram_en,
  output logic [BPU_ADDR_W-1:0] isram_addr,
  input  logic [BPU_INST_W-1:0] isram_rdata,
  output logic [BPU_INST_W-1:0] inst,
  output logic [BPU_ADDR_W-1:0] inst_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic                  busy
`ifdef BPU_FETCH_PERF_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int unsigned EntryW = BPU_ADDR_W + BPU_INST_W;
  localparam int unsigned CntW   = $clog2(FETCH_FIFO_DEPTH + 1);

  fetch_state_e          state;
  logic [BPU_ADDR_W-1:0] fetch_pc;
  logic                  epoch, req_epoch, rsp_epoch;
  logic                  rsp_valid;
  logic [BPU_ADDR_W-1:0] rsp_addr;
  logic [CntW-1:0]       fifo_count;
  logic                  fifo_empty, fifo_full;
  logic [EntryW-1:0]     fifo_head;
  logic                  redirect_act, rsp_ok, halt_hit, enq, deq, can_issue;

  assign redirect_act = redirect && (state != StIdle);
  // Responses tagged with a stale epoch belong to a flushed stream.
  assign rsp_ok       = rsp_valid && (rsp_epoch == epoch) && (state == StFetch);
  assign halt_hit     = rsp_ok && is_halt(isram_rdata);
  assign enq          = rsp_ok && !redirect_act;
  assign deq          = inst_valid && inst_ready;
  // Credit check counts every outstanding read, so the FIFO can never overflow.
  assign can_issue    = (state == StFetch) && !halt_hit && !redirect_act &&
                        ((32'(fifo_count) + 32'(isram_en) + 32'(rsp_valid)) < FETCH_FIFO_DEPTH);

  assign inst_valid   = !fifo_empty;
  assign {inst_pc, inst} = fifo_head;
  assign busy         = (state != StIdle);

  bpu_fetch_fifo #(
    .Depth (FETCH_FIFO_DEPTH),
    .Width (EntryW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (redirect_act),
    .wr_en   (enq),
    .wr_data ({rsp_addr, isram_rdata}),
    .rd_en   (deq),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      fetch_pc   <= '0;
      epoch      <= 1'b0;
      isram_en   <= 1'b0;
      isram_addr <= '0;
      req_epoch  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_epoch  <= 1'b0;
      rsp_addr   <= '0;
    end else begin
      isram_en  <= can_issue;
      req_epoch <= epoch;
      rsp_valid <= isram_en;
      rsp_epoch <= req_epoch;
      rsp_addr  <= isram_addr;
      if (can_issue) begin
        isram_addr <= fetch_pc;
        fetch_pc   <= fetch_pc + 1'b1;
      end
      if (redirect_act) begin
        epoch    <= ~epoch;
        fetch_pc <= redirect_addr;
        state    <= StFetch;
      end else begin
        unique case (state)
          StIdle: begin
            if (start) begin
              fetch_pc <= start_addr;
              state    <= StFetch;
            end
          end
          StFetch: begin
            if (halt_hit) state <= StDrain;
          end
          StDrain: begin
            if (deq && is_halt(inst)) state <= StIdle;
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

`ifdef BPU_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((state == StIdle) && start) begin
      stall_cnt <= '0;
    end else if (busy && !inst_valid && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bpu_inst_fetch.sv
// Directed bench for bpu_inst_fetch: latency, back-pressure, redirect, HALT, wrap, mid-run reset.
module tb_bpu_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] start_addr;
  logic        redirect;
  logic [15:0] redirect_addr;
  logic        isram_en;
  logic [15:0] isram_addr;
  logic [15:0] isram_rdata = '0;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        busy;
`ifdef BPU_FETCH_PERF_EN
  logic [31:0] stall_cnt;
`endif

  int          n_tests;
  int          n_fail;
  int          n_issue;
  logic [15:0] got_pc[$];
  logic [15:0] got_inst[$];
  logic        halt_on;
  logic [15:0] halt_addr;
  logic        ok_flag;

  always #5 clk = ~clk;

  bpu_inst_fetch u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .start_addr    (start_addr),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .isram_en      (isram_en),
    .isram_addr    (isram_addr),
    .isram_rdata   (isram_rdata),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .busy          (busy)
`ifdef BPU_FETCH_PERF_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  // SRAM model: word = address with bit 15 cleared, except an optional HALT location.
  function automatic logic [15:0] sram_word(input logic [15:0] a);
    if (halt_on && (a == halt_addr)) return 16'hF800;
    return {1'b0, a[14:0]};
  endfunction

  always @(posedge clk) begin
    if (isram_en) isram_rdata <= sram_word(isram_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Record the transfer (if any) about to happen, then advance one clock.
  task automatic cycle();
    if (rst_n && inst_valid && inst_ready) begin
      got_pc.push_back(inst_pc);
      got_inst.push_back(inst);
    end
    if (isram_en) n_issue++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_got();
    got_pc.delete();
    got_inst.delete();
  endtask

  task automatic wait_n(input int n, input int max_cyc, input string tag);
    int c = 0;
    while ((got_pc.size() < n) && (c < max_cyc)) begin
      cycle();
      c++;
    end
    check(tag, 32'(got_pc.size()), 32'(n));
  endtask

  function automatic logic [15:0] pc_at(input int i);
    return (got_pc.size() > i) ? got_pc[i] : 16'hDEAD;
  endfunction

  function automatic logic [15:0] inst_at(input int i);
    return (got_inst.size() > i) ? got_inst[i] : 16'hDEAD;
  endfunction

  task automatic reset_pulse();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  initial begin
    n_tests = 0; n_fail = 0; n_issue = 0;
    halt_on = 1'b0; halt_addr = '0;
    rst_n = 1'b0; start = 1'b0; start_addr = '0;
    redirect = 1'b0; redirect_addr = '0; inst_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", {29'd0, isram_en, inst_valid, busy}, 32'd0);
    check("rst_addr", 32'(isram_addr), 32'd0);
    check("rst_inst", {inst_pc, inst}, 32'd0);
    rst_n = 1'b1;
    cycle();

    // Latency and back-pressure: ready low from the start.
    start = 1'b1; start_addr = 16'h0010;
    cycle();
    start = 1'b0; n_issue = 0;
    check("lat_busy", 32'(busy), 32'd1);
    check("lat_en_t0", 32'(isram_en), 32'd0);
    cycle();
    check("lat_en_t1", 32'(isram_en), 32'd1);
    check("lat_addr_t1", 32'(isram_addr), 32'h0010);
    cycle();
    check("lat_valid_t2", 32'(inst_valid), 32'd0);
    cycle();
    check("lat_valid_t3", 32'(inst_valid), 32'd1);
    check("lat_pc_t3", 32'(inst_pc), 32'h0010);
    ok_flag = 1'b1;
    repeat (10) begin
      cycle();
      if (!(inst_valid && (inst_pc == 16'h0010) && (inst == 16'h0010))) ok_flag = 1'b0;
    end
    check("bp_hold", 32'(ok_flag), 32'd1);
    check("bp_en_low", 32'(isram_en), 32'd0);
    check("bp_issued", 32'(n_issue), 32'd4);
    inst_ready = 1'b1;
    clear_got();
    wait_n(8, 20, "bp_release_cnt");
    for (int i = 0; i < 8; i++) begin
      check("bp_order_pc", 32'(pc_at(i)), 32'h0010 + 32'(i));
      check("bp_order_inst", 32'(inst_at(i)), 32'h0010 + 32'(i));
    end

    // Streaming with ready high: one word per cycle from T+3.
    reset_pulse();
    start = 1'b1; start_addr = 16'h0010;
    cycle();
    start = 1'b0;
    repeat (3) cycle();
    check("stream_pc0", 32'(inst_pc), 32'h0010);
    ok_flag = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cycle();
      check("stream_pc", 32'(inst_pc), 32'h0010 + 32'(k));
      if (!(inst_valid && busy)) ok_flag = 1'b0;
    end
    check("stream_valid_busy", 32'(ok_flag), 32'd1);

    // Redirect with 3 buffered words and 1 read returning.
    inst_ready = 1'b0;
    reset_pulse();
    start = 1'b1; start_addr = 16'h0010;
    cycle();
    start = 1'b0;
    repeat (5) cycle();
    check("redir_pre_valid", 32'(inst_valid), 32'd1);
    redirect = 1'b1; redirect_addr = 16'h0100;
    cycle();
    redirect = 1'b0;
    check("redir_flush", 32'(inst_valid), 32'd0);
    clear_got();
    inst_ready = 1'b1;
    wait_n(4, 15, "redir_cnt");
    for (int i = 0; i < 4; i++) check("redir_pc", 32'(pc_at(i)), 32'h0100 + 32'(i));

    // HALT at 0x0013 entered via redirect while reads are in flight.
    halt_on = 1'b1; halt_addr = 16'h0013;
    redirect = 1'b1; redirect_addr = 16'h0010;
    cycle();
    redirect = 1'b0;
    clear_got();
    begin
      int c = 0;
      while (!((got_pc.size() > 0) && (got_pc[got_pc.size()-1] == 16'h0013)) && (c < 20)) begin
        cycle();
        c++;
      end
    end
    check("halt_busy", 32'(busy), 32'd0);
    repeat (5) cycle();
    check("halt_cnt", 32'(got_pc.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("halt_pc", 32'(pc_at(i)), 32'h0010 + 32'(i));
    check("halt_word", 32'(inst_at(3)), 32'h0000F800);
    check("halt_idle", {30'd0, isram_en, inst_valid}, 32'd0);

    // Address wrap.
    halt_on = 1'b0;
    start = 1'b1; start_addr = 16'hFFFE;
    cycle();
    start = 1'b0;
    clear_got();
    wait_n(3, 15, "wrap_cnt");
    check("wrap_pc0", 32'(pc_at(0)), 32'h0000FFFE);
    check("wrap_pc1", 32'(pc_at(1)), 32'h0000FFFF);
    check("wrap_pc2", 32'(pc_at(2)), 32'h00000000);
    check("wrap_inst0", 32'(inst_at(0)), 32'h00007FFE);
    check("wrap_inst2", 32'(inst_at(2)), 32'h00000000);

    // Asynchronous reset mid-fetch, then a fresh start.
    repeat (2) cycle();
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ctrl", {29'd0, isram_en, inst_valid, busy}, 32'd0);
    check("mid_rst_addr", 32'(isram_addr), 32'd0);
    check("mid_rst_inst", {inst_pc, inst}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    clear_got();
    start = 1'b1; start_addr = 16'h0020;
    cycle();
    start = 1'b0;
    wait_n(1, 10, "post_rst_cnt");
    check("post_rst_pc", 32'(pc_at(0)), 32'h0020);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
